// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: opcodes, FSM states, iteration count.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int MULT_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Opcodes 000..011 all go through the iterative multiplier.
  function automatic logic is_mul_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/hilo_shift_add_core.sv
// Radix-2 shift-add unsigned multiplier datapath: one partial product per step, MULT_ITERS steps.
// o_last is high during the final step so the controller can leave RUN on that edge.
module hilo_shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplr,
  output logic [2*WIDTH-1:0] o_prod,
  output logic               o_last
);
  import hilo_pkg::*;

  localparam int CNT_W = $clog2(MULT_ITERS) + 1;

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     w_sum;

  // Carry out of the upper-half add becomes the new MSB after the right shift.
  assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_mplr[0] ? {1'b0, r_mcand} : '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_mcand <= i_mcand;
      r_mplr  <= i_mplr;
      r_prod  <= '0;
      r_cnt   <= CNT_W'(MULT_ITERS);
    end else if (i_step) begin
      r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  assign o_prod = r_prod;
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/hilo_mult_unit.sv
// HI/LO owner: MULT/MULTU/MADD/MSUB take 34 cycles (Busy 33, then Done); MTHI/MTLO write in one.
// Busy stalls the pipeline; any Start seen while Busy is dropped, not queued.
module hilo_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  import hilo_pkg::*;

  state_t             r_state;
  state_t             w_next;
  logic               r_busy;
  logic               r_done;
  logic               r_sign;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic               w_wr_hi;
  logic               w_wr_lo;
  logic               w_last;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_p;
  logic [2*WIDTH-1:0] w_hilo;
  logic [2*WIDTH-1:0] w_result;

  // The most negative operand maps to itself, which is its correct unsigned magnitude.
  assign w_signed = (i_op != OP_MULTU);
  assign w_mag_a  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mag_b  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  hilo_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_mcand (w_mag_a),
    .i_mplr  (w_mag_b),
    .o_prod  (w_prod),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start && is_mul_op(i_op)) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_FIX;
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_fix   = 1'b0;
    w_wr_hi = 1'b0;
    w_wr_lo = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) begin
        w_load  = is_mul_op(i_op);
        w_wr_hi = (i_op == OP_MTHI);
        w_wr_lo = (i_op == OP_MTLO);
      end
      ST_RUN:  w_step = 1'b1;
      ST_FIX:  w_fix  = 1'b1;
      default: ;
    endcase
  end

  assign w_p    = r_sign ? -w_prod : w_prod;
  assign w_hilo = {r_hi, r_lo};

  always_comb begin
    case (r_op)
      OP_MADD: w_result = w_hilo + w_p;
      OP_MSUB: w_result = w_hilo - w_p;
      default: w_result = w_p;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sign <= 1'b0;
      r_op   <= OP_MULT;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= w_fix | w_wr_hi | w_wr_lo;
      if (w_load) begin
        r_sign <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        r_op   <= i_op;
      end
      if (w_wr_hi) r_hi <= i_a;
      if (w_wr_lo) r_lo <= i_a;
      if (w_fix) {r_hi, r_lo} <= w_result;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
